// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: sequencer states, bus field widths and
// EBUS function codes used by the arbiter and its requesters.
package ebus_pkg;

    localparam int EBUS_CS_W   = 7;
    localparam int EBUS_FCN_W  = 3;
    localparam int EBUS_DATA_W = 36;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DEMAND,
        RELEASE,
        DONE
    } ebus_state_e;

    localparam logic [EBUS_FCN_W-1:0] CONO   = 3'o0;
    localparam logic [EBUS_FCN_W-1:0] CONI   = 3'o1;
    localparam logic [EBUS_FCN_W-1:0] DATAO  = 3'o2;
    localparam logic [EBUS_FCN_W-1:0] DATAI  = 3'o3;
    localparam logic [EBUS_FCN_W-1:0] PI_FCN = 3'o4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_i.
// Ports: req_i (requests), last_i (previous owner), win_o (one-hot), idx_o.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        logic [IW:0] j;
        logic        found;
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            // wrap last_i + i back into 0..N_REQ-1
            j = {1'b0, last_i} + (IW+1)'(i);
            if (j >= (IW+1)'(N_REQ)) begin
                j = j - (IW+1)'(N_REQ);
            end
            if (!found && req_i[j[IW-1:0]]) begin
                found            = 1'b1;
                win_o[j[IW-1:0]] = 1'b1;
                idx_o            = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ebus_arb.sv
// EBUS arbiter and cycle sequencer: grants the bus round-robin and runs
// the CS/function/DEMAND/XFER handshake for the owner.
// Ports: clk, CROBAR (sync reset); req*/grant/done/err/rdData requester
// side; ebus* device side. Option macro: EBUS_ARB_TIMEOUT_EN (XFER watchdog).
module ebus_arb
    import ebus_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                                    clk,
    input  logic                                    CROBAR,
    input  logic [N_REQ-1:0]                        req,
    input  logic [N_REQ-1:0][EBUS_CS_W-1:0]         reqCS,
    input  logic [N_REQ-1:0][EBUS_FCN_W-1:0]        reqFcn,
    input  logic [N_REQ-1:0]                        reqWrite,
    input  logic [N_REQ-1:0][EBUS_DATA_W-1:0]       reqData,
    output logic [N_REQ-1:0]                        grant,
    output logic [N_REQ-1:0]                        done,
    output logic                                    err,
    output logic [EBUS_DATA_W-1:0]                  rdData,
    output logic [EBUS_CS_W-1:0]                    ebusCS,
    output logic [EBUS_FCN_W-1:0]                   ebusFcn,
    output logic                                    ebusDemand,
    output logic                                    ebusDrive,
    output logic [EBUS_DATA_W-1:0]                  ebusDataOut,
    input  logic                                    ebusXfer,
    input  logic [EBUS_DATA_W-1:0]                  ebusDataIn
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    ebus_state_e              state_q;
    logic [IW-1:0]            owner_q;
    logic [IW-1:0]            last_q;
    logic [N_REQ-1:0]         grant_q;
    logic [N_REQ-1:0]         done_q;
    logic                     err_q;
    logic [EBUS_DATA_W-1:0]   rd_q;
    logic [EBUS_CS_W-1:0]     cs_q;
    logic [EBUS_FCN_W-1:0]    fcn_q;
    logic                     dem_q;
    logic                     drv_q;
    logic [EBUS_DATA_W-1:0]   dout_q;

    logic [N_REQ-1:0]         winHot;
    logic [IW-1:0]            winIdx;
    logic                     tmo;
    logic                     goDone;
    logic                     goErr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (winHot),
        .idx_o  (winIdx)
    );

`ifdef EBUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // cleared on entry to DEMAND and RELEASE, counts while waiting
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            cnt_q <= '0;
        end else if (state_q == SETUP ||
                     (state_q == DEMAND && ebusXfer)) begin
            cnt_q <= '0;
        end else if (state_q == DEMAND || state_q == RELEASE) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tmo = (cnt_q == CW'(TIMEOUT));
`else
    // without the watchdog the handshake waits forever
    assign tmo = (TIMEOUT < 0);
`endif

    assign goDone = (state_q == DEMAND && !ebusXfer && tmo) ||
                    (state_q == RELEASE && (!ebusXfer || tmo));
    // a RELEASE that ends with XFER still high is a timeout
    assign goErr  = (state_q == DEMAND) || ebusXfer;

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            cs_q    <= '0;
            fcn_q   <= '0;
            dem_q   <= 1'b0;
            drv_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            if (goDone) begin
                state_q <= DONE;
                done_q  <= grant_q;
                err_q   <= goErr;
                last_q  <= owner_q;
                dem_q   <= 1'b0;
                cs_q    <= '0;
                fcn_q   <= '0;
                drv_q   <= 1'b0;
                dout_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (|req) begin
                            owner_q <= winIdx;
                            grant_q <= winHot;
                            cs_q    <= reqCS[winIdx];
                            fcn_q   <= reqFcn[winIdx];
                            drv_q   <= reqWrite[winIdx];
                            dout_q  <= reqData[winIdx];
                            state_q <= SETUP;
                        end
                    end
                    SETUP: begin
                        dem_q   <= 1'b1;
                        state_q <= DEMAND;
                    end
                    DEMAND: begin
                        if (ebusXfer) begin
                            dem_q   <= 1'b0;
                            state_q <= RELEASE;
                            if (!drv_q) begin
                                rd_q <= ebusDataIn;
                            end
                        end
                    end
                    RELEASE: begin
                    end
                    DONE: begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdData      = rd_q;
    assign ebusCS      = cs_q;
    assign ebusFcn     = fcn_q;
    assign ebusDemand  = dem_q;
    assign ebusDrive   = drv_q;
    assign ebusDataOut = dout_q;

endmodule

// File: tb/tb_ebus_arb.sv
// Self-checking bench for ebus_arb: directed cycle tables, hand-written
// corner sequences and a randomized run against a transaction model.
module tb_ebus_arb;
    import ebus_pkg::*;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                CROBAR;
    logic [N-1:0]        req;
    logic [N-1:0][6:0]   reqCS;
    logic [N-1:0][2:0]   reqFcn;
    logic [N-1:0]        reqWrite;
    logic [N-1:0][35:0]  reqData;
    logic [N-1:0]        grant;
    logic [N-1:0]        done;
    logic                err;
    logic [35:0]         rdData;
    logic [6:0]          ebusCS;
    logic [2:0]          ebusFcn;
    logic                ebusDemand;
    logic                ebusDrive;
    logic [35:0]         ebusDataOut;
    logic                ebusXfer;
    logic [35:0]         ebusDataIn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ebus_arb #(
        .N_REQ   (N),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .CROBAR      (CROBAR),
        .req         (req),
        .reqCS       (reqCS),
        .reqFcn      (reqFcn),
        .reqWrite    (reqWrite),
        .reqData     (reqData),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .rdData      (rdData),
        .ebusCS      (ebusCS),
        .ebusFcn     (ebusFcn),
        .ebusDemand  (ebusDemand),
        .ebusDrive   (ebusDrive),
        .ebusDataOut (ebusDataOut),
        .ebusXfer    (ebusXfer),
        .ebusDataIn  (ebusDataIn)
    );

    typedef struct {
        logic [3:0]  req;
        logic [6:0]  csi;
        logic        xfer;
        logic [3:0]  g;
        logic        dem;
        logic [3:0]  dn;
        logic [35:0] rd;
        logic [6:0]  cs;
        logic [2:0]  fc;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [35:0] r36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[35:0];
    endfunction

    function automatic int oh2idx(input logic [N-1:0] g);
        if ($countones(g) != 1) return -1;
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic clr_in();
        req        = '0;
        reqCS      = '0;
        reqFcn     = '0;
        reqWrite   = '0;
        reqData    = '0;
        ebusXfer   = 1'b0;
        ebusDataIn = '0;
    endtask

    // returns at the negedge of the first IDLE cycle after reset
    task automatic do_reset();
        clr_in();
        CROBAR = 1'b1;
        @(negedge clk);
        CROBAR = 1'b0;
    endtask

    // full read by one requester with an immediately-acking device;
    // returns at the negedge of the IDLE cycle after done
    task automatic do_txn(input int idx, input logic [35:0] din);
        int n;
        req           = '0;
        req[idx]      = 1'b1;
        reqWrite[idx] = 1'b0;
        reqFcn[idx]   = DATAI;
        ebusDataIn    = din;
        n = 0;
        while (done[idx] !== 1'b1 && n < 20) begin
            ebusXfer = ebusDemand;
            if (grant != '0) req = '0;
            @(negedge clk);
            n++;
        end
        chk($sformatf("txn%0d.done", idx), done[idx], 1'b1);
        ebusXfer = 1'b0;
        req      = '0;
        @(negedge clk);
    endtask

    localparam logic [35:0] RV = 36'o123456701234;
    localparam logic [35:0] WV = 36'o777000777000;

    vec_t tv[8];

    initial begin
        int owners[$];
        int gaps[$];
        int expOwn[5];
        int gap;
        logic [N-1:0] pg;
        logic [35:0] r1;

        tv[0] = '{4'b0010, 7'o04, 1'b0, 4'b0000, 1'b0, 4'b0000, 36'o0, 7'o00, 3'o0};
        tv[1] = '{4'b0010, 7'o04, 1'b0, 4'b0010, 1'b0, 4'b0000, 36'o0, 7'o04, DATAI};
        tv[2] = '{4'b0000, 7'o55, 1'b0, 4'b0010, 1'b1, 4'b0000, 36'o0, 7'o04, DATAI};
        tv[3] = '{4'b0000, 7'o55, 1'b1, 4'b0010, 1'b1, 4'b0000, 36'o0, 7'o04, DATAI};
        tv[4] = '{4'b0000, 7'o55, 1'b1, 4'b0010, 1'b0, 4'b0000, RV,    7'o04, DATAI};
        tv[5] = '{4'b0000, 7'o55, 1'b0, 4'b0010, 1'b0, 4'b0000, RV,    7'o04, DATAI};
        tv[6] = '{4'b0000, 7'o55, 1'b0, 4'b0010, 1'b0, 4'b0010, RV,    7'o00, 3'o0};
        tv[7] = '{4'b0000, 7'o55, 1'b0, 4'b0000, 1'b0, 4'b0000, RV,    7'o00, 3'o0};

        // read by requester 1; req withdrawn during DEMAND
        do_reset();
        reqFcn[1]  = DATAI;
        ebusDataIn = RV;
        for (int i = 0; i < 8; i++) begin
            req      = tv[i].req;
            reqCS[1] = tv[i].csi;
            ebusXfer = tv[i].xfer;
            chk($sformatf("rd%0d.grant", i), grant, tv[i].g);
            chk($sformatf("rd%0d.dem", i), ebusDemand, tv[i].dem);
            chk($sformatf("rd%0d.done", i), done, tv[i].dn);
            chk($sformatf("rd%0d.rd", i), rdData, tv[i].rd);
            chk($sformatf("rd%0d.cs", i), ebusCS, tv[i].cs);
            chk($sformatf("rd%0d.fcn", i), ebusFcn, tv[i].fc);
            chk($sformatf("rd%0d.err", i), err, 1'b0);
            @(negedge clk);
        end

        // round-robin with all four requesting
        do_reset();
        req = '1;
        gap = 0;
        pg  = '0;
        expOwn = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 40 && owners.size() < 5; c++) begin
            ebusXfer = ebusDemand;
            if (grant == '0) gap++;
            else if (pg == '0) begin
                owners.push_back(oh2idx(grant));
                gaps.push_back(gap);
                gap = 0;
            end
            pg = grant;
            @(negedge clk);
        end
        chk("rr.count", owners.size(), 5);
        for (int i = 0; i < owners.size(); i++) begin
            chk($sformatf("rr%0d.owner", i), owners[i], expOwn[i]);
            chk($sformatf("rr%0d.gap", i), gaps[i], 1);
        end

        // write by requester 2
        do_reset();
        req         = 4'b0100;
        reqWrite[2] = 1'b1;
        reqData[2]  = WV;
        reqCS[2]    = 7'o10;
        reqFcn[2]   = DATAO;
        ebusDataIn  = 36'o555555555555;
        @(negedge clk);
        chk("wr.grant", grant, 4'b0100);
        chk("wr.drv1", ebusDrive, 1'b1);
        chk("wr.dout1", ebusDataOut, WV);
        chk("wr.fcn", ebusFcn, DATAO);
        req = '0;
        @(negedge clk);
        chk("wr.dem", ebusDemand, 1'b1);
        chk("wr.drv2", ebusDrive, 1'b1);
        chk("wr.dout2", ebusDataOut, WV);
        ebusXfer = 1'b1;
        @(negedge clk);
        chk("wr.drv3", ebusDrive, 1'b1);
        chk("wr.dout3", ebusDataOut, WV);
        chk("wr.dem3", ebusDemand, 1'b0);
        ebusXfer = 1'b0;
        @(negedge clk);
        chk("wr.done", done, 4'b0100);
        chk("wr.drv4", ebusDrive, 1'b0);
        chk("wr.dout4", ebusDataOut, 36'o0);
        chk("wr.cs4", ebusCS, 7'o0);
        chk("wr.rd", rdData, 36'o0);
        @(negedge clk);
        chk("wr.idle", grant, 4'b0000);

`ifdef EBUS_ARB_TIMEOUT_EN
        // device never answers; TIMEOUT=8
        do_reset();
        r1 = 36'o246024602460;
        do_txn(1, r1);
        ebusDataIn = 36'o111111111111;
        for (int c = 0; c <= 12; c++) begin
            ebusXfer = 1'b0;
            req = (c == 0) ? 4'b0010 : 4'b0000;
            if (c == 5) chk("to.dem", ebusDemand, 1'b1);
            if (c == 10) chk("to.early", {done, err}, 5'b0);
            if (c == 11) begin
                chk("to.done", done, 4'b0010);
                chk("to.err", err, 1'b1);
                chk("to.rd", rdData, r1);
            end
            if (c == 12) chk("to.grant", {grant, done, err}, 9'b0);
            @(negedge clk);
        end
`else
        r1 = '0;
`endif

        // reset in DEMAND clears everything, req[0] then beats req[3]
        do_reset();
        do_txn(0, RV);
        chk("rst.rdpre", rdData, RV);
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("rst.dem", ebusDemand, 1'b1);
        chk("rst.g3", grant, 4'b1000);
        CROBAR = 1'b1;
        req    = 4'b1001;
        @(negedge clk);
        chk("rst.outs", {grant, done, err, ebusCS, ebusFcn, ebusDemand,
                         ebusDrive}, 23'b0);
        chk("rst.rd", rdData, 36'o0);
        chk("rst.dout", ebusDataOut, 36'o0);
        CROBAR = 1'b0;
        @(negedge clk);
        chk("rst.win0", grant, 4'b0001);

        // randomized traffic against a transaction-level model
        do_reset();
        begin
            int lastOwn, s, k, m, own;
            logic busy, prevIdle, oW, tx;
            logic [6:0] oCS;
            logic [2:0] oF;
            logic [35:0] oD, rdM, dinK;
            logic [3:0] eg;
            lastOwn  = N - 1;
            busy     = 1'b0;
            prevIdle = 1'b1;
            rdM      = '0;
            dinK     = '0;
            s = 0; k = 0; m = 0; own = 0;
            oW = 1'b0; oCS = '0; oF = '0; oD = '0;
            for (int c = 0; c < 600; c++) begin
                if (!busy && prevIdle && req != '0) begin
                    own = -1;
                    for (int i = 1; i <= N; i++)
                        if (own < 0 && req[(lastOwn + i) % N])
                            own = (lastOwn + i) % N;
                    busy = 1'b1;
                    s    = c;
                    k    = c + 1 + int'($urandom_range(0, 3));
                    m    = k + int'($urandom_range(1, 3));
                    oCS  = reqCS[own];
                    oF   = reqFcn[own];
                    oW   = reqWrite[own];
                    oD   = reqData[own];
                end
                if (busy && c == k + 1 && !oW) rdM = dinK;
                tx = busy && c <= m;
                eg = busy ? 4'(1 << own) : 4'b0;
                chk("rnd.grant", grant, eg);
                chk("rnd.dem", ebusDemand, busy && c >= s + 1 && c <= k);
                chk("rnd.done", done, (busy && c == m + 1) ? eg : 4'b0);
                chk("rnd.err", err, 1'b0);
                chk("rnd.cs", ebusCS, tx ? oCS : 7'b0);
                chk("rnd.fcn", ebusFcn, tx ? oF : 3'b0);
                chk("rnd.drv", ebusDrive, tx ? oW : 1'b0);
                chk("rnd.dout", ebusDataOut, tx ? oD : 36'b0);
                chk("rnd.rd", rdData, rdM);
                prevIdle = !busy;
                if (busy && c == m + 1) begin
                    busy    = 1'b0;
                    lastOwn = own;
                end
                req = ($urandom_range(0, 9) < 3) ? 4'b0 :
                      4'($urandom_range(1, 15));
                for (int i = 0; i < N; i++) begin
                    reqCS[i]    = 7'($urandom);
                    reqFcn[i]   = 3'($urandom);
                    reqWrite[i] = 1'($urandom);
                    reqData[i]  = r36();
                end
                ebusXfer   = busy && c >= k && c < m;
                ebusDataIn = r36();
                if (busy && c == k) dinK = ebusDataIn;
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
